bmp280_i2c_target: RTL and testbench

// - Synthesizable I2C target emulating the BMP280 register map: the responder end of the bus our bmp280 host controller drives.
// - Lets the sensor path run in-system or in simulation without a physical sensor. Raw temp/pressure are fed from fabric, e.g. a ring-oscillator counter.
// - Sits on the open-drain SCL/SDA pads; SCL is input-only (no clock stretching).

---
 rtl/bmp280_i2c_target.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_bmp280_i2c_target.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp280_i2c_target.sv
// bmp280_i2c_target: I2C responder emulating the BMP280 register map (chip id, ctrl_meas, config, raw data).
// Latency: SCL/SDA go through SYNC_STAGES flops plus one edge-detect flop; SDA drive changes 1 clk after a synced SCL fall.
// Backpressure: none -- SCL is input-only (no clock stretching), so clk must be >= 8x the SCL rate.
//
// Ports:
//   clk, rstn             system clock, async active-low reset
//   scl_i, sda_i          open-drain pad inputs
//   sda_oe                1 = pull SDA low
//   temp_raw, press_raw   20-bit raw samples from fabric, snapshotted at each read address-ACK
//   ctrl_meas, config_reg register 0xF4 / 0xF5 contents
//   wr_strobe             one-clk pulse after an accepted register write
//   busy                  1 from an addressed START until STOP
// Build option: define BMP280_TARGET_CALIB_EN to serve the CALIB table at 0x88..0xA1.

module bmp280_i2c_target #(
   parameter logic [6:0]   I2C_ADDR    = 7'h76,
   parameter logic [7:0]   CHIP_ID     = 8'h58,
   parameter int           SYNC_STAGES = 2,
   parameter logic [207:0] CALIB       = 208'h0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   input  logic [19:0] temp_raw,
   input  logic [19:0] press_raw,
   output logic [7:0]  ctrl_meas,
   output logic [7:0]  config_reg,
   output logic        wr_strobe,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_MACK,
      S_WAIT
   } state_t;

   localparam int         CALIB_BYTES = $bits(CALIB) / 8;
   localparam logic [7:0] CALIB_FIRST = 8'h88;
   localparam logic [7:0] CALIB_LAST  = 8'(CALIB_FIRST + CALIB_BYTES - 1);

   // ------------------------------------------------------------------
   // Pad synchronizers and bus-condition detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_q;
   logic                   sda_q;
   logic                   scl_s;
   logic                   sda_s;

   // Idle bus is high on both lines, so the chain resets high to avoid
   // a phantom edge right after reset release.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_q    <= scl_sync[SYNC_STAGES-1];
         sda_q    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign scl_rise  =  scl_s & ~scl_q;
   assign scl_fall  = ~scl_s &  scl_q;
   assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
   assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

   // ------------------------------------------------------------------
   // Protocol state
   // ------------------------------------------------------------------
   state_t      state;
   logic [2:0]  bit_cnt;
   logic [7:0]  sh;         // receive shift register, reused to shift read data out
   logic [7:0]  ptr;
   logic        rd_mode;
   logic        ack_on;     // second half of an ACK slot: we are holding SDA low
   logic        mack_ok;    // master ACKed the last read byte
   logic [19:0] temp_sh;
   logic [19:0] press_sh;
   logic [7:0]  rd_byte;
   logic [7:0]  rx_byte;

   assign rx_byte = {sh[6:0], sda_s};

   // ------------------------------------------------------------------
   // Read map; raw data comes from the per-transaction shadow copy
   // ------------------------------------------------------------------
   logic in_calib;
   assign in_calib = (ptr >= CALIB_FIRST) && (ptr <= CALIB_LAST);

`ifdef BMP280_TARGET_CALIB_EN
   logic [7:0]   calib_idx;
   logic [207:0] calib_shift;
   assign calib_idx   = ptr - CALIB_FIRST;
   assign calib_shift = CALIB << {calib_idx, 3'b000};
`endif

   always_comb begin
      rd_byte = 8'h00;
      case (ptr)
         8'hD0:   rd_byte = CHIP_ID;
         8'hF3:   rd_byte = 8'h00;    // never reports measuring / NVM copy
         8'hF4:   rd_byte = ctrl_meas;
         8'hF5:   rd_byte = config_reg;
         8'hF7:   rd_byte = press_sh[19:12];
         8'hF8:   rd_byte = press_sh[11:4];
         8'hF9:   rd_byte = {press_sh[3:0], 4'h0};
         8'hFA:   rd_byte = temp_sh[19:12];
         8'hFB:   rd_byte = temp_sh[11:4];
         8'hFC:   rd_byte = {temp_sh[3:0], 4'h0};
         default: begin
`ifdef BMP280_TARGET_CALIB_EN
            if (in_calib) rd_byte = calib_shift[207:200];
`else
            // Without the table the calibration window simply reads zero.
            if (in_calib) rd_byte = 8'h00;
`endif
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Main FSM. START/STOP override every state; START has priority over
   // any SCL edge seen in the same cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         bit_cnt    <= 3'd0;
         sh         <= 8'h00;
         ptr        <= 8'h00;
         rd_mode    <= 1'b0;
         ack_on     <= 1'b0;
         mack_ok    <= 1'b0;
         temp_sh    <= 20'h0;
         press_sh   <= 20'h0;
         sda_oe     <= 1'b0;
         ctrl_meas  <= 8'h00;
         config_reg <= 8'h00;
         wr_strobe  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         if (start_det) begin
            // Repeated START keeps the pointer so write-ptr/Sr/read works.
            state   <= S_ADDR;
            bit_cnt <= 3'd0;
            ack_on  <= 1'b0;
            mack_ok <= 1'b0;
            sda_oe  <= 1'b0;
         end else if (stop_det) begin
            state   <= S_IDLE;
            ack_on  <= 1'b0;
            mack_ok <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               S_ADDR: begin
                  if (scl_rise) begin
                     sh      <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (rx_byte[7:1] == I2C_ADDR) begin
                           state   <= S_ADDR_ACK;
                           rd_mode <= rx_byte[0];
                           busy    <= 1'b1;
                           if (rx_byte[0]) begin
                              temp_sh  <= temp_raw;
                              press_sh <= press_raw;
                           end
                        end else begin
                           state <= S_WAIT;
                        end
                     end
                  end
               end

               // ACK slots: first SCL fall grabs SDA, second fall ends the slot.
               S_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on) begin
                        ack_on <= 1'b1;
                        sda_oe <= 1'b1;
                     end else begin
                        ack_on  <= 1'b0;
                        bit_cnt <= 3'd0;
                        if (rd_mode) begin
                           sh     <= rd_byte;
                           sda_oe <= ~rd_byte[7];
                           state  <= S_RDATA;
                        end else begin
                           sda_oe <= 1'b0;
                           state  <= S_PTR;
                        end
                     end
                  end
               end

               S_PTR: begin
                  if (scl_rise) begin
                     sh      <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ptr   <= rx_byte;
                        state <= S_PTR_ACK;
                     end
                  end
               end

               S_PTR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on) begin
                        ack_on <= 1'b1;
                        sda_oe <= 1'b1;
                     end else begin
                        ack_on  <= 1'b0;
                        bit_cnt <= 3'd0;
                        sda_oe  <= 1'b0;
                        state   <= S_WDATA;
                     end
                  end
               end

               S_WDATA: begin
                  if (scl_rise) begin
                     sh      <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) state <= S_WDATA_ACK;
                  end
               end

               // The register write commits only once the ACK slot has
               // completed, so a STOP inside a byte leaves registers untouched.
               S_WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on) begin
                        ack_on <= 1'b1;
                        sda_oe <= 1'b1;
                     end else begin
                        ack_on  <= 1'b0;
                        bit_cnt <= 3'd0;
                        sda_oe  <= 1'b0;
                        state   <= S_WDATA;
                        ptr     <= ptr + 8'd1;
                        case (ptr)
                           8'hF4: begin
                              ctrl_meas <= sh;
                              wr_strobe <= 1'b1;
                           end
                           8'hF5: begin
                              config_reg <= sh;
                              wr_strobe  <= 1'b1;
                           end
                           8'hE0: begin
                              if (sh == 8'hB6) begin
                                 ctrl_meas  <= 8'h00;
                                 config_reg <= 8'h00;
                                 wr_strobe  <= 1'b1;
                              end
                           end
                           default: ;
                        endcase
                     end
                  end
               end

               // Bit 7 is already on the wire when this state is entered;
               // each SCL fall presents the next bit.
               S_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state   <= S_MACK;
                        mack_ok <= 1'b0;
                        ptr     <= ptr + 8'd1;
                     end
                  end else if (scl_fall) begin
                     sh     <= {sh[6:0], 1'b0};
                     sda_oe <= ~sh[6];
                  end
               end

               // First fall releases SDA for the master's ACK bit, the rise
               // samples it, the next fall launches the following byte.
               S_MACK: begin
                  if (scl_rise) begin
                     if (sda_s) state <= S_WAIT;
                     else       mack_ok <= 1'b1;
                  end else if (scl_fall) begin
                     if (mack_ok) begin
                        mack_ok <= 1'b0;
                        sh      <= rd_byte;
                        sda_oe  <= ~rd_byte[7];
                        bit_cnt <= 3'd0;
                        state   <= S_RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                     end
                  end
               end

               S_IDLE, S_WAIT: ;

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bmp280_i2c_target.sv
module tb_bmp280_i2c_target;

   localparam logic [207:0] CALIB_TB = {8'hA5, 8'h3C, 192'h0};

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        scl = 1'b1;
   logic        m_sda = 1'b1;
   logic        sda_line;
   logic        sda_oe;
   logic [19:0] temp_raw;
   logic [19:0] press_raw;
   logic [7:0]  ctrl_meas;
   logic [7:0]  config_reg;
   logic        wr_strobe;
   logic        busy;

   assign sda_line = m_sda & ~sda_oe;

   bmp280_i2c_target #(.CALIB(CALIB_TB)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .scl_i      (scl),
      .sda_i      (sda_line),
      .sda_oe     (sda_oe),
      .temp_raw   (temp_raw),
      .press_raw  (press_raw),
      .ctrl_meas  (ctrl_meas),
      .config_reg (config_reg),
      .wr_strobe  (wr_strobe),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int strobe_cyc = 0;

   // Register-map model: what the target must hold after each completed byte.
   logic [7:0]  m_ptr = 8'h00;
   logic [7:0]  m_ctrl = 8'h00;
   logic [7:0]  m_cfg = 8'h00;
   int          m_strobes = 0;
   logic        m_first = 1'b0;
   logic        m_wait = 1'b0;
   logic [19:0] snap_t = 20'h0;
   logic [19:0] snap_p = 20'h0;
   logic        exp_oe = 1'b0;
   logic        exp_busy = 1'b0;
   logic        chk_win = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (a == 8'hD0) return 8'h58;
      if (a == 8'hF4) return m_ctrl;
      if (a == 8'hF5) return m_cfg;
      if (a == 8'hF7) return snap_p[19:12];
      if (a == 8'hF8) return snap_p[11:4];
      if (a == 8'hF9) return {snap_p[3:0], 4'h0};
      if (a == 8'hFA) return snap_t[19:12];
      if (a == 8'hFB) return snap_t[11:4];
      if (a == 8'hFC) return {snap_t[3:0], 4'h0};
`ifdef BMP280_TARGET_CALIB_EN
      if (a >= 8'h88 && a <= 8'hA1) begin
         logic [207:0] t;
         t = CALIB_TB >> (8 * (8'hA1 - a));
         return t[7:0];
      end
`endif
      return 8'h00;
   endfunction

   // Outputs are stable in the second part of each SCL-high phase.
   always @(negedge clk) begin
      if (chk_win) begin
         chk("sda_oe", 32'(sda_oe), 32'(exp_oe));
         chk("ctrl_meas", 32'(ctrl_meas), 32'(m_ctrl));
         chk("config_reg", 32'(config_reg), 32'(m_cfg));
         chk("busy", 32'(busy), 32'(exp_busy));
      end
   end

   always @(negedge clk) if (wr_strobe) strobe_cyc++;

   // One SCL bit: data set while low, sampled mid-high.
   task automatic bit_xfer(input logic drv, input logic e_oe, output logic line);
      m_sda = drv;
      #60 scl = 1'b1;
      exp_oe = e_oe;
      #40 chk_win = 1'b1;
      #20 line = sda_line;
      #60 chk_win = 1'b0;
      scl = 1'b0;
      #60;
   endtask

   task automatic i2c_start;
      m_sda = 1'b1;
      #60 scl = 1'b1;
      #60 m_sda = 1'b0;
      #60 scl = 1'b0;
      exp_oe = 1'b0;
      #60;
   endtask

   task automatic i2c_stop;
      m_sda = 1'b0;
      #60 scl = 1'b1;
      #60 m_sda = 1'b1;
      #60 exp_busy = 1'b0;
      exp_oe = 1'b0;
      m_wait = 1'b0;
      chk_win = 1'b1;
      #40 chk_win = 1'b0;
      #20;
   endtask

   task automatic addr_phase(input logic [6:0] a, input logic rw);
      logic [7:0] b;
      logic       l;
      logic       match;
      logic       ack;
      b = {a, rw};
      match = (a == 7'h76);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && match) exp_busy = 1'b1;
         bit_xfer(b[i], 1'b0, l);
      end
      bit_xfer(1'b1, match, l);
      ack = ~l;
      chk("addr_ack", 32'(ack), 32'(match));
      m_wait = ~match;
      m_first = 1'b1;
      if (match && rw) begin
         snap_t = temp_raw;
         snap_p = press_raw;
      end
   endtask

   task automatic wr_byte(input logic [7:0] b);
      logic l;
      logic ack;
      logic want;
      want = ~m_wait;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], 1'b0, l);
      bit_xfer(1'b1, want, l);
      ack = ~l;
      chk("wr_ack", 32'(ack), 32'(want));
      if (!m_wait) begin
         if (m_first) begin
            m_ptr = b;
            m_first = 1'b0;
         end else begin
            if (m_ptr == 8'hF4) begin m_ctrl = b; m_strobes++; end
            if (m_ptr == 8'hF5) begin m_cfg = b; m_strobes++; end
            if (m_ptr == 8'hE0 && b == 8'hB6) begin
               m_ctrl = 8'h00;
               m_cfg = 8'h00;
               m_strobes++;
            end
            m_ptr = m_ptr + 8'd1;
         end
      end
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] got);
      logic [7:0] e;
      logic       l;
      e = m_read(m_ptr);
      m_ptr = m_ptr + 8'd1;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, ~e[i], l);
         got[i] = l;
      end
      bit_xfer(~mack, 1'b0, l);
      if (!mack) m_wait = 1'b1;
      chk("rd_model", 32'(got), 32'(e));
   endtask

   task automatic chk_strobes(input int lit);
      chk("strobe_model", 32'(strobe_cyc), 32'(m_strobes));
      chk("strobe_count", 32'(strobe_cyc), 32'(lit));
   endtask

   logic [7:0] got;
   logic [7:0] exp_c0;
   logic [7:0] exp_c1;
   logic       dummy;

   initial begin
      temp_raw = 20'h0;
      press_raw = 20'h0;
      repeat (3) @(negedge clk);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_ctrl", 32'(ctrl_meas), 32'd0);
      chk("rst_cfg", 32'(config_reg), 32'd0);
      chk("rst_strobe", 32'(wr_strobe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // Write ctrl_meas = 0x27
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF4); wr_byte(8'h27); i2c_stop;
      chk("ctrl_0x27", 32'(ctrl_meas), 32'h27);
      chk_strobes(1);

      // Write config = 0xA0
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF5); wr_byte(8'hA0); i2c_stop;
      chk("cfg_0xA0", 32'(config_reg), 32'hA0);
      chk_strobes(2);

      // Chip ID via write-ptr / Sr / read with NACK
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hD0);
      i2c_start; addr_phase(7'h76, 1'b1); rd_byte(1'b0, got);
      chk("chip_id", 32'(got), 32'h58);
      chk("oe_after_nack", 32'(sda_oe), 32'd0);
      i2c_stop;

      // Temperature burst with the live value changing mid-burst
      temp_raw = 20'hABCDE;
      press_raw = 20'h54321;
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hFA);
      i2c_start; addr_phase(7'h76, 1'b1);
      rd_byte(1'b1, got); chk("temp_msb", 32'(got), 32'hAB);
      temp_raw = 20'h12345;
      rd_byte(1'b1, got); chk("temp_lsb", 32'(got), 32'hCD);
      rd_byte(1'b0, got); chk("temp_xlsb", 32'(got), 32'hE0);
      i2c_stop;

      // Pressure burst
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF7);
      i2c_start; addr_phase(7'h76, 1'b1);
      rd_byte(1'b1, got); chk("press_msb", 32'(got), 32'h54);
      rd_byte(1'b1, got); chk("press_lsb", 32'(got), 32'h32);
      rd_byte(1'b0, got); chk("press_xlsb", 32'(got), 32'h10);
      i2c_stop;

      // Foreign address: no ACK, nothing written
      i2c_start; addr_phase(7'h77, 1'b0); wr_byte(8'hF4); wr_byte(8'h00); i2c_stop;
      chk("ctrl_after_foreign", 32'(ctrl_meas), 32'h27);

      // Pointer wrap 0xFF -> 0x00, then persistence to 0x01
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hFF);
      i2c_start; addr_phase(7'h76, 1'b1);
      rd_byte(1'b1, got); chk("wrap_ff", 32'(got), 32'h00);
      rd_byte(1'b0, got); chk("wrap_00", 32'(got), 32'h00);
      i2c_stop;
      chk("model_ptr_wrap", 32'(m_ptr), 32'h01);
      i2c_start; addr_phase(7'h76, 1'b1); rd_byte(1'b0, got); i2c_stop;
      chk("read_01", 32'(got), 32'h00);

      // Pointer persists across transactions
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF4); i2c_stop;
      i2c_start; addr_phase(7'h76, 1'b1);
      rd_byte(1'b1, got); chk("persist_f4", 32'(got), 32'h27);
      rd_byte(1'b0, got); chk("persist_f5", 32'(got), 32'hA0);
      i2c_stop;

      // Writes outside the map are ACKed but ignored
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hD0); wr_byte(8'h11); i2c_stop;
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hE0); wr_byte(8'h12); i2c_stop;
      chk_strobes(2);

      // Burst write with auto-increment
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF4); wr_byte(8'h55); wr_byte(8'hAA); i2c_stop;
      chk("burst_ctrl", 32'(ctrl_meas), 32'h55);
      chk("burst_cfg", 32'(config_reg), 32'hAA);
      chk_strobes(4);

      // STOP inside a data byte discards it
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF5);
      for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, dummy);
      i2c_stop;
      chk("partial_cfg", 32'(config_reg), 32'hAA);
      chk_strobes(4);

      // Soft reset
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hE0); wr_byte(8'hB6); i2c_stop;
      chk("softrst_ctrl", 32'(ctrl_meas), 32'h00);
      chk("softrst_cfg", 32'(config_reg), 32'h00);
      chk_strobes(5);

      // Async reset while the target is driving a 0 bit
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF4); wr_byte(8'h55); i2c_stop;
      chk_strobes(6);
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'hF4);
      i2c_start; addr_phase(7'h76, 1'b1);
      m_sda = 1'b1;
      #60 scl = 1'b1;
      #60 chk("oe_before_rst", 32'(sda_oe), 32'd1);
      rstn = 1'b0;
      #1;
      chk("rst_mid_oe", 32'(sda_oe), 32'd0);
      chk("rst_mid_ctrl", 32'(ctrl_meas), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      #59 rstn = 1'b1;
      m_ptr = 8'h00;
      m_ctrl = 8'h00;
      m_cfg = 8'h00;
      exp_busy = 1'b0;
      exp_oe = 1'b0;
      scl = 1'b0;
      #60;
      i2c_stop;
      i2c_start; addr_phase(7'h76, 1'b1); rd_byte(1'b0, got); i2c_stop;
      chk("read_after_rst", 32'(got), 32'h00);

      // Calibration window
`ifdef BMP280_TARGET_CALIB_EN
      exp_c0 = 8'hA5;
      exp_c1 = 8'h3C;
`else
      exp_c0 = 8'h00;
      exp_c1 = 8'h00;
`endif
      i2c_start; addr_phase(7'h76, 1'b0); wr_byte(8'h88);
      i2c_start; addr_phase(7'h76, 1'b1);
      rd_byte(1'b1, got); chk("calib_88", 32'(got), 32'(exp_c0));
      rd_byte(1'b0, got); chk("calib_89", 32'(got), 32'(exp_c1));
      i2c_stop;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
